// File: rtl/mor1kx_rf_access_ctrl_cappuccino.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_rf_access_ctrl_cappuccino
// Purpose  : Arbitrates the single GPR register-file write port between
//            pipeline writeback, SPR-bus GPR writes (group 0, 0x400-0x5FF)
//            and an optional post-reset clear sweep. Also sequences SPR-bus
//            GPR reads through a dedicated synchronous RF read port, with
//            forwarding of writebacks that race the read.
// Config   : MOR1KX_RF_CLEAR_ON_RESET_EN - when defined, reset enters a
//            clear sweep that zeroes RF words 0..RF_WORDS-1 before first use.
// Ports    :
//   clk, rst_n                     clock, async active-low reset
//   wb_rf_wb_i/wb_rfd_adr_i/
//   wb_result_i                    pipeline writeback (highest priority)
//   padv_ctrl_i                    ctrl stage advancing; SPR reads wait for 0
//   spr_bus_addr_i/stb/we/dat      SPR bus request
//   spr_gpr_ack_o/spr_gpr_dat_o    one-cycle ack and read data
//   rf_wren_o/rf_wradr_o/
//   rf_wrdat_o                     shared RF write port
//   rf_rden_o/rf_rdadr_o/
//   rf_rddat_i                     SPR read port (data one cycle later)
//   init_busy_o                    clear sweep in progress
// Revision : 1.0 - initial release
// ============================================================================
module mor1kx_rf_access_ctrl_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int RF_ADDR_WIDTH        = 5,
  parameter int RF_WORDS             = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wb_rf_wb_i,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_i,
  input  logic                            padv_ctrl_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  output logic                            rf_wren_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
  output logic                            rf_rden_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_rdadr_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_rddat_i,
  output logic                            init_busy_o
);

  typedef enum logic [2:0] {
`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
    ST_CLEAR = 3'd0,
`endif
    ST_IDLE  = 3'd1,
    ST_WR    = 3'd2,
    ST_RD    = 3'd3,
    ST_RDD   = 3'd4,
    ST_ACK   = 3'd5,
    ST_HOLD  = 3'd6
  } state_t;

  state_t                          state_q, state_d;
  logic                            op_wr_q, op_wr_d;
  logic                            fwd_q, fwd_d;
  logic [OPTION_OPERAND_WIDTH-1:0] fwd_dat_q, fwd_dat_d;
  logic [OPTION_OPERAND_WIDTH-1:0] dat_r_q, dat_r_d;
`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
  logic [RF_ADDR_WIDTH-1:0]        clr_cnt_q, clr_cnt_d;
`endif

  logic                     gpr_req;
  logic [RF_ADDR_WIDTH-1:0] spr_idx;
  logic                     wb_hit;
  // Address bits 8..RF_ADDR_WIDTH carry no meaning for the GPR window.
  logic                     addr_unused;

  assign gpr_req     = spr_bus_stb_i && (spr_bus_addr_i[15:9] == 7'h2);
  assign spr_idx     = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
  assign wb_hit      = wb_rf_wb_i && (wb_rfd_adr_i == spr_idx);
  assign addr_unused = ^spr_bus_addr_i;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
`else
      state_q   <= ST_IDLE;
`endif
      op_wr_q   <= 1'b0;
      fwd_q     <= 1'b0;
      fwd_dat_q <= '0;
      dat_r_q   <= '0;
    end else begin
`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
      clr_cnt_q <= clr_cnt_d;
`endif
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      fwd_q     <= fwd_d;
      fwd_dat_q <= fwd_dat_d;
      dat_r_q   <= dat_r_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    fwd_d     = fwd_q;
    fwd_dat_d = fwd_dat_q;
    dat_r_d   = dat_r_q;
`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        // A writeback steals the port; the clear word is retried next cycle.
        if (!wb_rf_wb_i) begin
          if (clr_cnt_q == RF_ADDR_WIDTH'(RF_WORDS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + RF_ADDR_WIDTH'(1);
          end
        end
      end
`endif
      ST_IDLE: begin
        if (gpr_req && spr_bus_we_i) begin
          state_d = ST_WR;
          op_wr_d = 1'b1;
        end else if (gpr_req && !padv_ctrl_i) begin
          state_d = ST_RD;
          op_wr_d = 1'b0;
        end
      end
      ST_WR: begin
        // The write itself happens whenever the port is free, even if the
        // strobe has just dropped; only the ack depends on the strobe.
        if (!wb_rf_wb_i) begin
          state_d = spr_bus_stb_i ? ST_ACK : ST_IDLE;
        end else if (!spr_bus_stb_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        fwd_d     = wb_hit;
        fwd_dat_d = wb_result_i;
        state_d   = spr_bus_stb_i ? ST_RDD : ST_IDLE;
      end
      ST_RDD: begin
        if (spr_bus_stb_i) begin
          // Newest value wins: this cycle's writeback, then the one seen
          // while the RAM read was in flight, then the RAM itself.
          if (wb_hit) begin
            dat_r_d = wb_result_i;
          end else if (fwd_q) begin
            dat_r_d = fwd_dat_q;
          end else begin
            dat_r_d = rf_rddat_i;
          end
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = spr_bus_stb_i ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!spr_bus_stb_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shared write port: writeback > clear > SPR write
  // --------------------------------------------------------------------------
  always_comb begin
    rf_wren_o  = 1'b0;
    rf_wradr_o = '0;
    rf_wrdat_o = '0;
    if (wb_rf_wb_i) begin
      rf_wren_o  = 1'b1;
      rf_wradr_o = wb_rfd_adr_i;
      rf_wrdat_o = wb_result_i;
    end
`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
    else if (state_q == ST_CLEAR) begin
      rf_wren_o  = 1'b1;
      rf_wradr_o = clr_cnt_q;
      rf_wrdat_o = '0;
    end
`endif
    else if (state_q == ST_WR) begin
      rf_wren_o  = 1'b1;
      rf_wradr_o = spr_idx;
      rf_wrdat_o = spr_bus_dat_i;
    end
  end

  // --------------------------------------------------------------------------
  // SPR read port and bus response
  // --------------------------------------------------------------------------
  assign rf_rden_o     = (state_q == ST_RD);
  assign rf_rdadr_o    = (state_q == ST_RD) ? spr_idx : '0;
  assign spr_gpr_ack_o = (state_q == ST_ACK);
  // Write acks return zero; otherwise the last read result is held.
  assign spr_gpr_dat_o = ((state_q == ST_ACK) && op_wr_q) ? '0 : dat_r_q;

`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
  assign init_busy_o = (state_q == ST_CLEAR);
`else
  assign init_busy_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_rf_access_ctrl_cappuccino.sv
`default_nettype none
// ============================================================================
// Module   : tb_mor1kx_rf_access_ctrl_cappuccino
// Purpose  : Directed scoreboard bench. Stimulus pushes expected RF writes,
//            RF read requests and SPR acks (with absolute cycle numbers) into
//            queues; a negedge monitor pops and compares whenever the DUT
//            presents one of those events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mor1kx_rf_access_ctrl_cappuccino;

  logic        clk;
  logic        rst_n;
  logic        wb_rf_wb_i;
  logic [4:0]  wb_rfd_adr_i;
  logic [31:0] wb_result_i;
  logic        padv_ctrl_i;
  logic [15:0] spr_bus_addr_i;
  logic        spr_bus_stb_i;
  logic        spr_bus_we_i;
  logic [31:0] spr_bus_dat_i;
  logic        spr_gpr_ack_o;
  logic [31:0] spr_gpr_dat_o;
  logic        rf_wren_o;
  logic [4:0]  rf_wradr_o;
  logic [31:0] rf_wrdat_o;
  logic        rf_rden_o;
  logic [4:0]  rf_rdadr_o;
  logic [31:0] rf_rddat_i;
  logic        init_busy_o;

  mor1kx_rf_access_ctrl_cappuccino #(
    .OPTION_OPERAND_WIDTH(32),
    .RF_ADDR_WIDTH(5),
    .RF_WORDS(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wb_rf_wb_i(wb_rf_wb_i),
    .wb_rfd_adr_i(wb_rfd_adr_i),
    .wb_result_i(wb_result_i),
    .padv_ctrl_i(padv_ctrl_i),
    .spr_bus_addr_i(spr_bus_addr_i),
    .spr_bus_stb_i(spr_bus_stb_i),
    .spr_bus_we_i(spr_bus_we_i),
    .spr_bus_dat_i(spr_bus_dat_i),
    .spr_gpr_ack_o(spr_gpr_ack_o),
    .spr_gpr_dat_o(spr_gpr_dat_o),
    .rf_wren_o(rf_wren_o),
    .rf_wradr_o(rf_wradr_o),
    .rf_wrdat_o(rf_wrdat_o),
    .rf_rden_o(rf_rden_o),
    .rf_rdadr_o(rf_rdadr_o),
    .rf_rddat_i(rf_rddat_i),
    .init_busy_o(init_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM stand-in: read-before-write, data one cycle after rden.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rf_wren_o) mem[rf_wradr_o] <= rf_wrdat_o;
    if (rf_rden_o) rf_rddat_i <= mem[rf_rdadr_o];
  end

  typedef struct {
    int          cyc;
    logic [4:0]  adr;
    logic [31:0] dat;
  } ev_t;

  ev_t wq[$];
  ev_t rq[$];
  ev_t aq[$];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void cmp_ev(string nm, ev_t e, logic [4:0] a, logic [31:0] d);
    n_cmp++;
    if (e.cyc != cyc || e.adr !== a || e.dat !== d) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d adr=%0d dat=%h, expected cyc=%0d adr=%0d dat=%h",
               nm, cyc, a, d, e.cyc, e.adr, e.dat);
    end
  endfunction

  function automatic void unexpected(string nm, logic [4:0] a, logic [31:0] d);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got unexpected event adr=%0d dat=%h at cycle %0d, expected none",
             nm, a, d, cyc);
  endfunction

  function automatic void missing(string nm, ev_t e);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got nothing by cycle %0d, expected cyc=%0d adr=%0d dat=%h",
             nm, cyc, e.cyc, e.adr, e.dat);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) missing("rf_write", wq.pop_front());
      while (rq.size() > 0 && rq[0].cyc < cyc) missing("rf_read", rq.pop_front());
      while (aq.size() > 0 && aq[0].cyc < cyc) missing("spr_ack", aq.pop_front());
      if (rf_wren_o) begin
        if (wq.size() == 0) unexpected("rf_write", rf_wradr_o, rf_wrdat_o);
        else cmp_ev("rf_write", wq.pop_front(), rf_wradr_o, rf_wrdat_o);
      end
      if (rf_rden_o) begin
        if (rq.size() == 0) unexpected("rf_read", rf_rdadr_o, 32'h0);
        else cmp_ev("rf_read", rq.pop_front(), rf_rdadr_o, 32'h0);
      end
      if (spr_gpr_ack_o) begin
        if (aq.size() == 0) unexpected("spr_ack", 5'd0, spr_gpr_dat_o);
        else cmp_ev("spr_ack", aq.pop_front(), 5'd0, spr_gpr_dat_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(int c, int a, logic [31:0] d);
    ev_t e;
    e.cyc = c; e.adr = a[4:0]; e.dat = d;
    wq.push_back(e);
  endtask

  task automatic push_r(int c, int a);
    ev_t e;
    e.cyc = c; e.adr = a[4:0]; e.dat = 32'h0;
    rq.push_back(e);
  endtask

  task automatic push_a(int c, logic [31:0] d);
    ev_t e;
    e.cyc = c; e.adr = 5'd0; e.dat = d;
    aq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  int t;

  initial begin
    rst_n          = 1'b0;
    wb_rf_wb_i     = 1'b0;
    wb_rfd_adr_i   = '0;
    wb_result_i    = '0;
    padv_ctrl_i    = 1'b0;
    spr_bus_addr_i = '0;
    spr_bus_stb_i  = 1'b0;
    spr_bus_we_i   = 1'b0;
    spr_bus_dat_i  = '0;
    repeat (3) tick();

    // Reset state; write port follows writeback even in reset.
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd7; wb_result_i = 32'h77;
    @(negedge clk);
    chk("reset_ack", {31'h0, spr_gpr_ack_o}, 32'h0);
    chk("reset_dat", spr_gpr_dat_o, 32'h0);
    chk("reset_rden", {31'h0, rf_rden_o}, 32'h0);
`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
    chk("reset_busy", {31'h0, init_busy_o}, 32'h1);
`else
    chk("reset_busy", {31'h0, init_busy_o}, 32'h0);
`endif
    chk("reset_wren", {31'h0, rf_wren_o}, 32'h1);
    chk("reset_wradr", {27'h0, rf_wradr_o}, 32'h7);
    chk("reset_wrdat", rf_wrdat_o, 32'h77);
    tick();
    wb_rf_wb_i = 1'b0;
    tick();
    rst_n = 1'b1;
    t = cyc;

`ifdef MOR1KX_RF_CLEAR_ON_RESET_EN
    // Abort the sweep at count 12, then run a full sweep.
    for (int i = 0; i <= 12; i++) push_w(t + i, i, 32'h0);
    repeat (13) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    t = cyc;
    for (int i = 0; i < 32; i++) push_w(t + i, i, 32'h0);
    repeat (31) tick();
    @(negedge clk);
    chk("clear_busy_last", {31'h0, init_busy_o}, 32'h1);
    tick();
    @(negedge clk);
    chk("clear_busy_done", {31'h0, init_busy_o}, 32'h0);
`else
    @(negedge clk);
    chk("idle_busy", {31'h0, init_busy_o}, 32'h0);
`endif
    tick();

    // Preload RF[10] = 0x1234 via writeback
    t = cyc;
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd10; wb_result_i = 32'h1234;
    push_w(t, 10, 32'h1234);
    tick();
    wb_rf_wb_i = 1'b0;

    // SPR write 0x405 with two cycles of writeback conflict
    t = cyc;
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b1;
    spr_bus_addr_i = 16'h0405; spr_bus_dat_i = 32'hDEADBEEF;
    push_w(t + 1, 3, 32'h111);
    push_w(t + 2, 4, 32'h222);
    push_w(t + 3, 5, 32'hDEADBEEF);
    push_a(t + 4, 32'h0);
    tick();
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd3; wb_result_i = 32'h111;
    tick();
    wb_rfd_adr_i = 5'd4; wb_result_i = 32'h222;
    tick();
    wb_rf_wb_i = 1'b0;
    tick();
    spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0;
    tick();

    // Plain read of RF[10]
    t = cyc;
    spr_bus_stb_i = 1'b1; spr_bus_addr_i = 16'h040A;
    push_r(t + 1, 10);
    push_a(t + 3, 32'h1234);
    repeat (3) tick();
    spr_bus_stb_i = 1'b0;
    tick();

    // Read with same-index writeback in the RD cycle
    t = cyc;
    spr_bus_stb_i = 1'b1; spr_bus_addr_i = 16'h040A;
    push_r(t + 1, 10);
    push_w(t + 1, 10, 32'hCAFE);
    push_a(t + 3, 32'hCAFE);
    tick();
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd10; wb_result_i = 32'hCAFE;
    tick();
    wb_rf_wb_i = 1'b0;
    tick();
    spr_bus_stb_i = 1'b0;
    tick();

    // Restore RF[10] = 0x1234
    t = cyc;
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd10; wb_result_i = 32'h1234;
    push_w(t, 10, 32'h1234);
    tick();
    wb_rf_wb_i = 1'b0;

    // Read with same-index writeback in the RDD cycle
    t = cyc;
    spr_bus_stb_i = 1'b1; spr_bus_addr_i = 16'h040A;
    push_r(t + 1, 10);
    push_w(t + 2, 10, 32'hCAFE);
    push_a(t + 3, 32'hCAFE);
    tick();
    tick();
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd10; wb_result_i = 32'hCAFE;
    tick();
    wb_rf_wb_i = 1'b0; spr_bus_stb_i = 1'b0;
    tick();

    // Read of RF[5] stalled by padv_ctrl_i for 4 cycles; strobe held after ack
    t = cyc;
    spr_bus_stb_i = 1'b1; spr_bus_addr_i = 16'h0405; padv_ctrl_i = 1'b1;
    repeat (4) tick();
    padv_ctrl_i = 1'b0;
    push_r(t + 5, 5);
    push_a(t + 7, 32'hDEADBEEF);
    repeat (3) tick();
    tick();
    @(negedge clk);
    chk("dat_hold", spr_gpr_dat_o, 32'hDEADBEEF);
    repeat (2) tick();
    spr_bus_stb_i = 1'b0;
    tick();

    // Uncontended write then read of RF[31]
    t = cyc;
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b1;
    spr_bus_addr_i = 16'h041F; spr_bus_dat_i = 32'hA5A5;
    push_w(t + 1, 31, 32'hA5A5);
    push_a(t + 2, 32'h0);
    repeat (2) tick();
    spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0;
    tick();
    t = cyc;
    spr_bus_stb_i = 1'b1;
    push_r(t + 1, 31);
    push_a(t + 3, 32'hA5A5);
    repeat (3) tick();
    spr_bus_stb_i = 1'b0;
    tick();

    // Read strobe dropped during RD: request issued, no ack
    t = cyc;
    spr_bus_stb_i = 1'b1; spr_bus_addr_i = 16'h040A;
    push_r(t + 1, 10);
    tick();
    spr_bus_stb_i = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("drop_dat_kept", spr_gpr_dat_o, 32'hA5A5);

    // Non-GPR address: ignored
    tick();
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b1;
    spr_bus_addr_i = 16'h0011; spr_bus_dat_i = 32'h55;
    repeat (3) tick();
    spr_bus_we_i = 1'b0;
    repeat (3) tick();
    spr_bus_stb_i = 1'b0;
    repeat (5) tick();

    @(negedge clk);
    chk("wq_drained", wq.size(), 32'h0);
    chk("rq_drained", rq.size(), 32'h0);
    chk("aq_drained", aq.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
